// File: rtl/ram_1r2w_wr_sched.sv
// Round-robin write scheduler for a 1-read/2-write register RAM, up to two grants per cycle.
// Optional RD_BYPASS_EN: forward the issue-stage write data to the read port on an address match.
module ram_1r2w_wr_sched #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*INDEX-1:0] req_addr_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [INDEX-1:0]      addr0wr_o,
    output logic [WIDTH-1:0]      data0wr_o,
    output logic                  we0_o,
    output logic [INDEX-1:0]      addr1wr_o,
    output logic [WIDTH-1:0]      data1wr_o,
    output logic                  we1_o,
    input  logic [INDEX-1:0]      rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic [INDEX-1:0]      ram_addr0_o,
    input  logic [WIDTH-1:0]      ram_data0_i
);
    localparam int PW = $clog2(NREQ);

    // Handshake: a write is accepted in the cycle where req_valid_i[i] && req_ready_o[i];
    // ready is a function of valid, so valid must never wait on ready.

    logic [PW-1:0]    rr_ptr;
    logic [NREQ-1:0]  grant;
    logic             found0, found1;
    logic [PW-1:0]    last_idx, rr_next;
    logic [INDEX-1:0] s0_addr, s1_addr;
    logic [WIDTH-1:0] s0_data, s1_data;
    logic             we0_q, we1_q;

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        last_idx = '0;
        s0_addr  = '0;
        s1_addr  = '0;
        s0_data  = '0;
        s1_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid_i[idx] && !found1) begin
                if (!found0) begin
                    found0     = 1'b1;
                    grant[idx] = 1'b1;
                    last_idx   = PW'(idx);
                    s0_addr    = req_addr_i[idx*INDEX +: INDEX];
                    s0_data    = req_data_i[idx*WIDTH +: WIDTH];
                end else if (req_addr_i[idx*INDEX +: INDEX] != s0_addr) begin
                    // Same-address requesters are skipped so both ports never hit one entry.
                    found1     = 1'b1;
                    grant[idx] = 1'b1;
                    last_idx   = PW'(idx);
                    s1_addr    = req_addr_i[idx*INDEX +: INDEX];
                    s1_data    = req_data_i[idx*WIDTH +: WIDTH];
                end
            end
        end
        rr_next = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + PW'(1);
    end

    assign req_ready_o = reset ? '0 : grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            we0_q     <= 1'b0;
            we1_q     <= 1'b0;
            addr0wr_o <= '0;
            data0wr_o <= '0;
            addr1wr_o <= '0;
            data1wr_o <= '0;
        end else begin
            we0_q <= found0;
            we1_q <= found1;
            if (found0) begin
                rr_ptr    <= rr_next;
                addr0wr_o <= s0_addr;
                data0wr_o <= s0_data;
            end
            if (found1) begin
                addr1wr_o <= s1_addr;
                data1wr_o <= s1_data;
            end
        end
    end

    // Gating by reset drops a write that was registered just before reset arrived.
    assign we0_o = we0_q && !reset;
    assign we1_o = we1_q && !reset;

    assign ram_addr0_o = rd_addr_i;

`ifdef RD_BYPASS_EN
    always_comb begin
        rd_data_o = ram_data0_i;
        if (we0_o && (addr0wr_o == rd_addr_i))      rd_data_o = data0wr_o;
        else if (we1_o && (addr1wr_o == rd_addr_i)) rd_data_o = data1wr_o;
    end
`else
    assign rd_data_o = ram_data0_i;
`endif

endmodule

// File: tb/tb_ram_1r2w_wr_sched.sv
// Directed bench for ram_1r2w_wr_sched with a behavioural 16x8 RAM attached to its ports.
module tb_ram_1r2w_wr_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  addr0wr_o, addr1wr_o;
    logic [7:0]  data0wr_o, data1wr_o;
    logic        we0_o, we1_o;
    logic [3:0]  rd_addr_i;
    logic [7:0]  rd_data_o;
    logic [3:0]  ram_addr0_o;
    logic [7:0]  ram_data0_i;

    logic [7:0]  mem [16];
    logic [7:0]  exp_byp;
    int          n_assert = 0;
    int          n_fail   = 0;

    ram_1r2w_wr_sched #(.NREQ(4), .DEPTH(16), .INDEX(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .addr0wr_o(addr0wr_o), .data0wr_o(data0wr_o), .we0_o(we0_o),
        .addr1wr_o(addr1wr_o), .data1wr_o(data1wr_o), .we1_o(we1_o),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .ram_addr0_o(ram_addr0_o), .ram_data0_i(ram_data0_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we0_o) mem[addr0wr_o] <= data0wr_o;
        if (we1_o) mem[addr1wr_o] <= data1wr_o;
    end
    assign ram_data0_i = mem[ram_addr0_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [7:0] d);
        req_valid_i[i]         = v;
        req_addr_i[i*4 +: 4]   = a;
        req_data_i[i*8 +: 8]   = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        reset = 1'b1;
        rd_addr_i = 4'd0;
        set_req(0, 1'b1, 4'd1, 8'h11);
        set_req(1, 1'b1, 4'd2, 8'h22);
        set_req(2, 1'b1, 4'd3, 8'h33);
        set_req(3, 1'b1, 4'd4, 8'h44);

        // Reset held two cycles with every requester valid.
        step();
        chk("rst_ready_c1", req_ready_o, 4'b0000);
        chk("rst_we0_c1", we0_o, 1'b0);
        chk("rst_we1_c1", we1_o, 1'b0);
        step();
        chk("rst_ready_c2", req_ready_o, 4'b0000);
        chk("rst_addr0", addr0wr_o, 4'd0);
        chk("rst_data1", data1wr_o, 8'h00);

        // All four valid, distinct addresses: grants {0,1} then {2,3}.
        reset = 1'b0;
        settle();
        chk("rr_ready_01", req_ready_o, 4'b0011);
        step();
        chk("rr_we0_a", we0_o, 1'b1);
        chk("rr_we1_a", we1_o, 1'b1);
        chk("rr_addr0_a", addr0wr_o, 4'd1);
        chk("rr_addr1_a", addr1wr_o, 4'd2);
        chk("rr_data0_a", data0wr_o, 8'h11);
        chk("rr_data1_a", data1wr_o, 8'h22);
        chk("rr_ready_23", req_ready_o, 4'b1100);
        step();
        chk("rr_addr0_b", addr0wr_o, 4'd3);
        chk("rr_addr1_b", addr1wr_o, 4'd4);
        chk("rr_data1_b", data1wr_o, 8'h44);
        chk("rr_ready_01_again", req_ready_o, 4'b0011);
        req_valid_i = 4'b0000;
        step();
        chk("idle_we0", we0_o, 1'b0);
        chk("idle_we1", we1_o, 1'b0);
        chk("idle_addr0_hold", addr0wr_o, 4'd3);
        chk("idle_data1_hold", data1wr_o, 8'h44);
        rd_addr_i = 4'd4;
        settle();
        chk("mem4_read", rd_data_o, 8'h44);

        // Same-address requesters 0 and 2: serialised on port 0, later one wins.
        set_req(0, 1'b1, 4'd5, 8'hAA);
        set_req(2, 1'b1, 4'd5, 8'hBB);
        settle();
        chk("conf_ready_c1", req_ready_o, 4'b0001);
        step();
        chk("conf_we0_c1", we0_o, 1'b1);
        chk("conf_we1_c1", we1_o, 1'b0);
        chk("conf_data0_c1", data0wr_o, 8'hAA);
        req_valid_i[0] = 1'b0;
        settle();
        chk("conf_ready_c2", req_ready_o, 4'b0100);
        step();
        chk("conf_we0_c2", we0_o, 1'b1);
        chk("conf_we1_c2", we1_o, 1'b0);
        chk("conf_addr0_c2", addr0wr_o, 4'd5);
        chk("conf_data0_c2", data0wr_o, 8'hBB);
        req_valid_i = 4'b0000;
        step();
        rd_addr_i = 4'd5;
        settle();
        chk("conf_mem5", rd_data_o, 8'hBB);

        // rr_ptr is now 3: requesters 3 and 0 wrap into one cycle.
        set_req(3, 1'b1, 4'd9, 8'h93);
        set_req(0, 1'b1, 4'd10, 8'h0A);
        settle();
        chk("wrap_ready", req_ready_o, 4'b1001);
        step();
        chk("wrap_addr0", addr0wr_o, 4'd9);
        chk("wrap_data0", data0wr_o, 8'h93);
        chk("wrap_addr1", addr1wr_o, 4'd10);
        chk("wrap_data1", data1wr_o, 8'h0A);
        chk("wrap_we1", we1_o, 1'b1);
        set_req(1, 1'b1, 4'd2, 8'h22);
        set_req(2, 1'b1, 4'd3, 8'h33);
        settle();
        chk("wrap_ptr_is_1", req_ready_o, 4'b0110);
        req_valid_i = 4'b0000;

        // Read bypass: write to 7 is visible a cycle early only with RD_BYPASS_EN.
        set_req(1, 1'b1, 4'd7, 8'h5C);
        settle();
        chk("byp_ready", req_ready_o, 4'b0010);
        step();
        req_valid_i = 4'b0000;
        rd_addr_i = 4'd7;
        settle();
        chk("byp_we0", we0_o, 1'b1);
        chk("byp_ram_addr", ram_addr0_o, 4'd7);
`ifdef RD_BYPASS_EN
        exp_byp = 8'h5C;
`else
        exp_byp = 8'h00;
`endif
        chk("byp_rd_early", rd_data_o, exp_byp);
        step();
        chk("byp_rd_late", rd_data_o, 8'h5C);

        // Single requester (rr_ptr=2) granted back-to-back on port 0.
        set_req(2, 1'b1, 4'd12, 8'h01);
        settle();
        chk("single_ready_c1", req_ready_o, 4'b0100);
        step();
        chk("single_data0_c1", data0wr_o, 8'h01);
        set_req(2, 1'b1, 4'd12, 8'h02);
        settle();
        chk("single_ready_c2", req_ready_o, 4'b0100);
        step();
        chk("single_we0_c2", we0_o, 1'b1);
        chk("single_data0_c2", data0wr_o, 8'h02);
        chk("single_we1_c2", we1_o, 1'b0);
        req_valid_i = 4'b0000;

        // Reset the cycle after a grant: the in-flight write is dropped.
        step();
        set_req(3, 1'b1, 4'd14, 8'hEE);
        settle();
        chk("rstw_ready", req_ready_o, 4'b1000);
        step();
        reset = 1'b1;
        req_valid_i = 4'b0000;
        rd_addr_i = 4'd14;
        settle();
        chk("rstw_we0_gated", we0_o, 1'b0);
        step();
        chk("rstw_we0_after", we0_o, 1'b0);
        chk("rstw_mem14", rd_data_o, 8'h00);
        reset = 1'b0;
        req_valid_i = 4'b1111;
        settle();
        chk("rstw_ptr_zero", req_ready_o, 4'b0011);
        req_valid_i = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
